// File: rtl/cpu_pkg.sv
// Shared core definitions: datapath widths, integer opcodes and the issue-queue
// entry layout used by the integer, load/store, multiply and divide queues.
package cpu_pkg;

    localparam int W_TAG  = 6;
    localparam int W_DATA = 32;
    localparam int W_OP   = 3;

    localparam logic [W_OP-1:0] OP_ADD = 3'b000;
    localparam logic [W_OP-1:0] OP_SUB = 3'b001;
    localparam logic [W_OP-1:0] OP_AND = 3'b010;
    localparam logic [W_OP-1:0] OP_OR  = 3'b011;
    localparam logic [W_OP-1:0] OP_SLT = 3'b100;

    typedef struct packed {
        logic              valid;
        logic [W_OP-1:0]   opcode;
        logic [W_TAG-1:0]  rdtag;
        logic [W_TAG-1:0]  rstag;
        logic [W_TAG-1:0]  rttag;
        logic [W_DATA-1:0] rsdata;
        logic [W_DATA-1:0] rtdata;
        logic              rsvalid;
        logic              rtvalid;
    } iq_entry_t;

endpackage

// File: rtl/equeue_int_if.sv
// Dispatch, CDB and issue signals of the integer issue queue.
// slave is the queue side, master is the surrounding pipeline.
interface equeue_int_if;
    import cpu_pkg::*;

    logic [W_OP-1:0]   dispatch_opcode;
    logic              dispatch_en;
    logic              dispatch_ready;
    logic [W_TAG-1:0]  dispatch_rdtag;
    logic [W_TAG-1:0]  dispatch_rstag;
    logic [W_TAG-1:0]  dispatch_rttag;
    logic [W_DATA-1:0] dispatch_rsdata;
    logic [W_DATA-1:0] dispatch_rtdata;
    logic              dispatch_rsvalid;
    logic              dispatch_rtvalid;
    logic [W_TAG-1:0]  cdb_tag;
    logic              cdb_valid;
    logic [W_DATA-1:0] cdb_data;
    logic [W_OP-1:0]   issueint_opcode;
    logic [W_TAG-1:0]  issueint_rdtag;
    logic [W_DATA-1:0] issueint_rsdata;
    logic [W_DATA-1:0] issueint_rtdata;
    logic              issueint_ready;
    logic              issueint_done;

    modport slave (
        input  dispatch_opcode, dispatch_en, dispatch_rdtag, dispatch_rstag,
               dispatch_rttag, dispatch_rsdata, dispatch_rtdata,
               dispatch_rsvalid, dispatch_rtvalid,
               cdb_tag, cdb_valid, cdb_data, issueint_done,
        output dispatch_ready, issueint_opcode, issueint_rdtag,
               issueint_rsdata, issueint_rtdata, issueint_ready
    );

    modport master (
        output dispatch_opcode, dispatch_en, dispatch_rdtag, dispatch_rstag,
               dispatch_rttag, dispatch_rsdata, dispatch_rtdata,
               dispatch_rsvalid, dispatch_rtvalid,
               cdb_tag, cdb_valid, cdb_data, issueint_done,
        input  dispatch_ready, issueint_opcode, issueint_rdtag,
               issueint_rsdata, issueint_rtdata, issueint_ready
    );

endinterface

// File: rtl/equeue_int_entry.sv
// One issue-queue slot: selects its next contents (dispatch, upper neighbour,
// clear or hold) and applies CDB wakeup to whatever it is about to hold.
module equeue_int_entry
    import cpu_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              load_disp,
    input  logic              load_up,
    input  logic              clear,
    input  iq_entry_t         disp_in,
    input  iq_entry_t         up_in,
    input  logic              cdb_valid,
    input  logic [W_TAG-1:0]  cdb_tag,
    input  logic [W_DATA-1:0] cdb_data,
    output iq_entry_t         ent_q
);

    iq_entry_t base_s;
    iq_entry_t ent_d;

    // Source of the slot's next contents
    always_comb begin
        base_s = ent_q;
        if (load_disp) begin
            base_s = disp_in;
        end else if (load_up) begin
            base_s = up_in;
        end else if (clear) begin
            base_s = '0;
        end else begin
            base_s = ent_q;
        end
    end

    // Wakeup is applied after the move, so shifted and freshly dispatched entries never miss a broadcast
    always_comb begin
        ent_d = base_s;
        if (base_s.valid && cdb_valid && !base_s.rsvalid && (base_s.rstag == cdb_tag)) begin
            ent_d.rsdata  = cdb_data;
            ent_d.rsvalid = 1'b1;
        end else begin
            ent_d.rsvalid = base_s.rsvalid;
        end
        if (base_s.valid && cdb_valid && !base_s.rtvalid && (base_s.rttag == cdb_tag)) begin
            ent_d.rtdata  = cdb_data;
            ent_d.rtvalid = 1'b1;
        end else begin
            ent_d.rtvalid = base_s.rtvalid;
        end
    end

    // Slot register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ent_q <= '0;
        end else begin
            ent_q <= ent_d;
        end
    end

endmodule

// File: rtl/equeue_int.sv
// Integer-ALU reservation station: collapsing queue, oldest-ready-first select,
// CDB wakeup and same-cycle dispatch forwarding.
module equeue_int
    import cpu_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         reset,
    equeue_int_if.slave  bus
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam int CNT_W = IDX_W + 1;

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;
    iq_entry_t        ent_s  [DEPTH];
    iq_entry_t        up_s   [DEPTH];
    iq_entry_t        disp_s;
    logic [DEPTH-1:0] load_disp_s;
    logic [DEPTH-1:0] load_up_s;
    logic [DEPTH-1:0] clear_s;
    logic             found_s;
    logic [IDX_W-1:0] sel_s;
    logic             wr_s;
    logic             rm_s;

    assign bus.dispatch_ready = (count_q < CNT_W'(DEPTH));
    assign wr_s = bus.dispatch_en & bus.dispatch_ready;
    assign rm_s = bus.issueint_done & found_s;

    // Dispatch payload as a queue entry
    always_comb begin
        disp_s         = '0;
        disp_s.valid   = 1'b1;
        disp_s.opcode  = bus.dispatch_opcode;
        disp_s.rdtag   = bus.dispatch_rdtag;
        disp_s.rstag   = bus.dispatch_rstag;
        disp_s.rttag   = bus.dispatch_rttag;
        disp_s.rsdata  = bus.dispatch_rsdata;
        disp_s.rtdata  = bus.dispatch_rtdata;
        disp_s.rsvalid = bus.dispatch_rsvalid;
        disp_s.rtvalid = bus.dispatch_rtvalid;
    end

    // Oldest fully-ready entry; scanning downwards lets the lowest index win
    always_comb begin
        found_s = 1'b0;
        sel_s   = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (ent_s[i].valid && ent_s[i].rsvalid && ent_s[i].rtvalid) begin
                found_s = 1'b1;
                sel_s   = IDX_W'(i);
            end else begin
                found_s = found_s;
            end
        end
    end

    // Issue outputs are zeroed whenever nothing is presented
    always_comb begin
        if (found_s) begin
            bus.issueint_ready  = 1'b1;
            bus.issueint_opcode = ent_s[sel_s].opcode;
            bus.issueint_rdtag  = ent_s[sel_s].rdtag;
            bus.issueint_rsdata = ent_s[sel_s].rsdata;
            bus.issueint_rtdata = ent_s[sel_s].rtdata;
        end else begin
            bus.issueint_ready  = 1'b0;
            bus.issueint_opcode = '0;
            bus.issueint_rdtag  = '0;
            bus.issueint_rsdata = '0;
            bus.issueint_rtdata = '0;
        end
    end

    // Per-slot move control: above the removed slot everything shifts down, the write lands at the tail
    always_comb begin
        int cnt_i;
        int sel_i;
        cnt_i       = int'(count_q);
        sel_i       = int'(sel_s);
        load_disp_s = '0;
        load_up_s   = '0;
        clear_s     = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (rm_s && (i >= sel_i)) begin
                if (wr_s && (i == cnt_i - 1)) begin
                    load_disp_s[i] = 1'b1;
                end else if (i < cnt_i - 1) begin
                    load_up_s[i] = 1'b1;
                end else begin
                    clear_s[i] = 1'b1;
                end
            end else begin
                if (wr_s && (i == cnt_i)) begin
                    load_disp_s[i] = 1'b1;
                end else begin
                    load_disp_s[i] = 1'b0;
                end
            end
        end
    end

    // Occupancy update
    always_comb begin
        case ({wr_s, rm_s})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // Occupancy register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    for (genvar g = 0; g < DEPTH; g++) begin : gen_ent
        if (g < DEPTH - 1) begin : gen_up
            assign up_s[g] = ent_s[g+1];
        end else begin : gen_top
            assign up_s[g] = '0;
        end

        equeue_int_entry u_entry (
            .clk       (clk),
            .reset     (reset),
            .load_disp (load_disp_s[g]),
            .load_up   (load_up_s[g]),
            .clear     (clear_s[g]),
            .disp_in   (disp_s),
            .up_in     (up_s[g]),
            .cdb_valid (bus.cdb_valid),
            .cdb_tag   (bus.cdb_tag),
            .cdb_data  (bus.cdb_data),
            .ent_q     (ent_s[g])
        );
    end

endmodule

// File: tb/tb_equeue_int.sv
// Directed bench for equeue_int: stimulus pushes expected issue records, a
// negedge monitor pops and compares them on every accepted issue.
module tb_equeue_int;
    import cpu_pkg::*;

    typedef struct {
        logic [2:0]  op;
        logic [5:0]  rd;
        logic [31:0] rs;
        logic [31:0] rt;
    } exp_t;

    logic clk;
    logic reset;
    int   n_cmp;
    int   n_err;
    exp_t sb[$];

    equeue_int_if bus ();

    equeue_int #(.DEPTH(4)) u_dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_issue(input logic [2:0] op, input logic [5:0] rd,
                                input logic [31:0] rs, input logic [31:0] rt);
        exp_t e;
        e.op = op; e.rd = rd; e.rs = rs; e.rt = rt;
        sb.push_back(e);
    endtask

    task automatic disp(input logic [2:0] op, input logic [5:0] rd,
                        input logic [5:0] rst, input logic rsv, input logic [31:0] rsd,
                        input logic [5:0] rtt, input logic rtv, input logic [31:0] rtd);
        bus.dispatch_opcode  = op;
        bus.dispatch_rdtag   = rd;
        bus.dispatch_rstag   = rst;
        bus.dispatch_rsvalid = rsv;
        bus.dispatch_rsdata  = rsd;
        bus.dispatch_rttag   = rtt;
        bus.dispatch_rtvalid = rtv;
        bus.dispatch_rtdata  = rtd;
        bus.dispatch_en      = 1'b1;
        tick();
        bus.dispatch_en      = 1'b0;
    endtask

    task automatic cdb(input logic v, input logic [5:0] tag, input logic [31:0] data);
        bus.cdb_valid = v;
        bus.cdb_tag   = tag;
        bus.cdb_data  = data;
        tick();
        bus.cdb_valid = 1'b0;
    endtask

    task automatic issue_n(input int n);
        bus.issueint_done = 1'b1;
        for (int k = 0; k < n; k++) tick();
        bus.issueint_done = 1'b0;
    endtask

    // Scoreboard monitor: every accepted issue must match the oldest expected record
    always @(negedge clk) begin
        if (!reset && bus.issueint_ready && bus.issueint_done) begin
            if (sb.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL iss_unexpected: got rd %0d expected no issue", bus.issueint_rdtag);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("iss_op", 32'(bus.issueint_opcode), 32'(e.op));
                chk("iss_rd", 32'(bus.issueint_rdtag), 32'(e.rd));
                chk("iss_rs", bus.issueint_rsdata, e.rs);
                chk("iss_rt", bus.issueint_rtdata, e.rt);
            end
        end
    end

    initial begin
        n_cmp = 0;
        n_err = 0;
        reset = 1'b1;
        bus.dispatch_en = 1'b0;
        bus.dispatch_opcode = '0; bus.dispatch_rdtag = '0;
        bus.dispatch_rstag = '0;  bus.dispatch_rttag = '0;
        bus.dispatch_rsdata = '0; bus.dispatch_rtdata = '0;
        bus.dispatch_rsvalid = 1'b0; bus.dispatch_rtvalid = 1'b0;
        bus.cdb_valid = 1'b0; bus.cdb_tag = '0; bus.cdb_data = '0;
        bus.issueint_done = 1'b0;
        #12 reset = 1'b0;
        tick();

        // Reset state
        chk("rst_dready", 32'(bus.dispatch_ready), 32'd1);
        chk("rst_iready", 32'(bus.issueint_ready), 32'd0);
        chk("rst_op", 32'(bus.issueint_opcode), 32'd0);
        chk("rst_rd", 32'(bus.issueint_rdtag), 32'd0);
        chk("rst_rs", bus.issueint_rsdata, 32'd0);
        chk("rst_rt", bus.issueint_rtdata, 32'd0);

        // Both operands valid at dispatch
        expect_issue(OP_ADD, 6'd5, 32'd10, 32'd20);
        disp(OP_ADD, 6'd5, 6'd1, 1'b1, 32'd10, 6'd2, 1'b1, 32'd20);
        chk("add_ready", 32'(bus.issueint_ready), 32'd1);
        issue_n(1);
        chk("add_gone", 32'(bus.issueint_ready), 32'd0);

        // Pending rs, woken by CDB; unqualified broadcast ignored
        disp(OP_SUB, 6'd7, 6'd3, 1'b0, 32'd0, 6'd0, 1'b1, 32'd4);
        chk("sub_pend", 32'(bus.issueint_ready), 32'd0);
        cdb(1'b0, 6'd3, 32'h99);
        chk("sub_nowake", 32'(bus.issueint_ready), 32'd0);
        expect_issue(OP_SUB, 6'd7, 32'h55, 32'd4);
        cdb(1'b1, 6'd3, 32'h55);
        chk("sub_wake", 32'(bus.issueint_ready), 32'd1);
        chk("sub_rs", bus.issueint_rsdata, 32'h55);
        issue_n(1);

        // Fill, overflow attempt, wake a middle entry, then drain in order
        disp(OP_AND, 6'd10, 6'd20, 1'b0, 32'd0, 6'd0, 1'b1, 32'd0);
        disp(OP_OR,  6'd11, 6'd21, 1'b0, 32'd0, 6'd0, 1'b1, 32'd1);
        disp(OP_SLT, 6'd12, 6'd22, 1'b0, 32'd0, 6'd0, 1'b1, 32'd2);
        disp(OP_SUB, 6'd13, 6'd23, 1'b0, 32'd0, 6'd0, 1'b1, 32'd3);
        chk("full_dready", 32'(bus.dispatch_ready), 32'd0);
        disp(OP_ADD, 6'd14, 6'd24, 1'b1, 32'd7, 6'd0, 1'b1, 32'd8);
        chk("full_ignored", 32'(bus.issueint_ready), 32'd0);
        chk("full_still", 32'(bus.dispatch_ready), 32'd0);
        expect_issue(OP_SLT, 6'd12, 32'h222, 32'd2);
        cdb(1'b1, 6'd22, 32'h222);
        chk("mid_rd", 32'(bus.issueint_rdtag), 32'd12);
        issue_n(1);
        chk("mid_dready", 32'(bus.dispatch_ready), 32'd1);
        chk("mid_gone", 32'(bus.issueint_ready), 32'd0);
        expect_issue(OP_AND, 6'd10, 32'hA0, 32'd0);
        expect_issue(OP_OR,  6'd11, 32'hA1, 32'd1);
        expect_issue(OP_SUB, 6'd13, 32'hA3, 32'd3);
        cdb(1'b1, 6'd23, 32'hA3);
        chk("old_not_yet", 32'(bus.issueint_rdtag), 32'd13);
        cdb(1'b1, 6'd21, 32'hA1);
        cdb(1'b1, 6'd20, 32'hA0);
        chk("oldest_first", 32'(bus.issueint_rdtag), 32'd10);
        issue_n(3);
        chk("drain_empty", 32'(bus.issueint_ready), 32'd0);

        // Same-cycle dispatch forwarding
        bus.cdb_valid = 1'b1; bus.cdb_tag = 6'd9; bus.cdb_data = 32'hAB;
        expect_issue(OP_AND, 6'd30, 32'hAB, 32'd7);
        disp(OP_AND, 6'd30, 6'd9, 1'b0, 32'd0, 6'd1, 1'b1, 32'd7);
        bus.cdb_valid = 1'b0;
        chk("fwd_ready", 32'(bus.issueint_ready), 32'd1);
        chk("fwd_rs", bus.issueint_rsdata, 32'hAB);
        issue_n(1);

        // Oldest-first with collapse and simultaneous remove + write
        expect_issue(OP_OR,  6'd40, 32'd1, 32'd2);
        expect_issue(OP_SLT, 6'd41, 32'd3, 32'd4);
        expect_issue(OP_ADD, 6'd42, 32'd5, 32'd6);
        disp(OP_OR,  6'd40, 6'd0, 1'b1, 32'd1, 6'd0, 1'b1, 32'd2);
        disp(OP_SLT, 6'd41, 6'd0, 1'b1, 32'd3, 6'd0, 1'b1, 32'd4);
        chk("two_rd", 32'(bus.issueint_rdtag), 32'd40);
        bus.issueint_done = 1'b1;
        disp(OP_ADD, 6'd42, 6'd0, 1'b1, 32'd5, 6'd0, 1'b1, 32'd6);
        bus.issueint_done = 1'b0;
        chk("collapse_rd", 32'(bus.issueint_rdtag), 32'd41);
        issue_n(2);
        chk("collapse_empty", 32'(bus.issueint_ready), 32'd0);

        // Asynchronous reset with three live entries
        disp(OP_ADD, 6'd50, 6'd0, 1'b1, 32'd1, 6'd0, 1'b1, 32'd1);
        disp(OP_SUB, 6'd51, 6'd0, 1'b1, 32'd2, 6'd0, 1'b1, 32'd2);
        disp(OP_AND, 6'd52, 6'd0, 1'b1, 32'd3, 6'd0, 1'b1, 32'd3);
        chk("pre_rst_ready", 32'(bus.issueint_ready), 32'd1);
        #2 reset = 1'b1;
        #1;
        chk("arst_iready", 32'(bus.issueint_ready), 32'd0);
        chk("arst_dready", 32'(bus.dispatch_ready), 32'd1);
        chk("arst_rd", 32'(bus.issueint_rdtag), 32'd0);
        #3 reset = 1'b0;
        tick();
        chk("post_rst_ready", 32'(bus.issueint_ready), 32'd0);

        chk("sb_empty", 32'(sb.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
